// File: rtl/elevator_request_scheduler.sv
// SCAN-ordered elevator call scheduler: latches call edges, picks the next floor, and times the door dwell.
// Optional macro CALL_SYNC_EN inserts a two-flop synchroniser on call_btn ahead of edge detection.
module elevator_request_scheduler #(
  parameter int DWELL_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call_btn,
  input  logic [1:0] present_floor,
  input  logic       tick,
  output logic [1:0] requested_floor,
  output logic       door_open,
  output logic [3:0] pending,
  output logic       dir_up,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR} state_t;

  localparam logic [3:0] DWELL = 4'(DWELL_TICKS);

  // Lowest pending floor strictly above f; bit 2 flags a hit.
  function automatic logic [2:0] nearest_above(input logic [3:0] p, input logic [1:0] f);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (p[i] && (2'(i) > f)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // Highest pending floor strictly below f; bit 2 flags a hit.
  function automatic logic [2:0] nearest_below(input logic [3:0] p, input logic [1:0] f);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (p[i] && (2'(i) < f)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  state_t     state, state_nxt;
  logic [3:0] call_src, call_prev, call_edge;
  logic [3:0] edge_set, clr_mask, pend_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] req_nxt;
  logic       door_nxt, dir_nxt, enter_door;
  logic [2:0] up_c, dn_c;

`ifdef CALL_SYNC_EN
  logic [3:0] sync_a, sync_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 4'b0000;
      sync_b <= 4'b0000;
    end else begin
      sync_a <= call_btn;
      sync_b <= sync_a;
    end
  end

  assign call_src = sync_b;
`else
  assign call_src = call_btn;
`endif

  assign call_edge = call_src & ~call_prev;
  assign up_c      = nearest_above(pending, present_floor);
  assign dn_c      = nearest_below(pending, present_floor);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    req_nxt    = requested_floor;
    door_nxt   = door_open;
    dir_nxt    = dir_up;
    cnt_nxt    = cnt;
    edge_set   = call_edge;
    clr_mask   = 4'b0000;
    enter_door = 1'b0;

    case (state)
      IDLE: begin
        if (pending == 4'b0000) begin
          req_nxt = present_floor;
        end else if (pending[present_floor]) begin
          enter_door = 1'b1;
        end else begin
          state_nxt = MOVING;
          if (dir_up) begin
            if (up_c[2]) begin
              req_nxt = up_c[1:0];
            end else begin
              req_nxt = dn_c[1:0];
              dir_nxt = 1'b0;
            end
          end else begin
            if (dn_c[2]) begin
              req_nxt = dn_c[1:0];
            end else begin
              req_nxt = up_c[1:0];
              dir_nxt = 1'b1;
            end
          end
        end
      end

      MOVING: begin
        if (present_floor == requested_floor) begin
          enter_door = 1'b1;
        end else if (dir_up && up_c[2] && (up_c[1:0] < requested_floor)) begin
          req_nxt = up_c[1:0];
        end else if (!dir_up && dn_c[2] && (dn_c[1:0] > requested_floor)) begin
          req_nxt = dn_c[1:0];
        end
      end

      DOOR: begin
        req_nxt                = present_floor;
        // A call for the floor we are standing at just holds the door longer.
        edge_set[present_floor] = 1'b0;
        if (call_edge[present_floor]) begin
          cnt_nxt = DWELL;
        end else if (tick) begin
          if (cnt <= 4'd1) begin
            cnt_nxt   = 4'd0;
            door_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (enter_door) begin
      state_nxt               = DOOR;
      door_nxt                = 1'b1;
      cnt_nxt                 = DWELL;
      req_nxt                 = present_floor;
      clr_mask[present_floor] = 1'b1;
    end

    // Clear wins over a same-cycle set.
    pend_nxt = (pending | edge_set) & ~clr_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pending         <= 4'b0000;
      requested_floor <= 2'b00;
      door_open       <= 1'b0;
      dir_up          <= 1'b1;
      cnt             <= 4'd0;
      call_prev       <= 4'b0000;
    end else begin
      state           <= state_nxt;
      pending         <= pend_nxt;
      requested_floor <= req_nxt;
      door_open       <= door_nxt;
      dir_up          <= dir_nxt;
      cnt             <= cnt_nxt;
      call_prev       <= call_src;
    end
  end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler (default build, DWELL_TICKS = 3).
module tb_elevator_request_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] call_btn;
  logic [1:0] present_floor;
  logic       tick;
  logic [1:0] requested_floor;
  logic       door_open;
  logic [3:0] pending;
  logic       dir_up;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  elevator_request_scheduler #(.DWELL_TICKS(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .call_btn        (call_btn),
    .present_floor   (present_floor),
    .tick            (tick),
    .requested_floor (requested_floor),
    .door_open       (door_open),
    .pending         (pending),
    .dir_up          (dir_up),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_call(input logic [3:0] v);
    call_btn = v;
    cyc();
    call_btn = 4'b0000;
  endtask

  task automatic tick1();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] rf, input logic dor,
                         input logic [3:0] pd, input logic du, input logic bz);
    chk({tag, ".req"},  8'(rf),  8'(requested_floor));
    chk({tag, ".door"}, 8'(dor), 8'(door_open));
    chk({tag, ".pend"}, 8'(pd),  8'(pending));
    chk({tag, ".dir"},  8'(du),  8'(dir_up));
    chk({tag, ".busy"}, 8'(bz),  8'(busy));
  endtask

  initial begin
    reset = 1'b1; call_btn = 4'b0000; present_floor = 2'd0; tick = 1'b0;
    #1;
    chk_all("rst_hold", 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle with no calls stays parked at floor 0.
    repeat (6) cyc();
    chk_all("idle", 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0);

    // Single call to floor 3 from floor 0.
    pulse_call(4'b1000);
    chk("c3.pend", pending, 8'h08);
    chk("c3.busy0", busy, 1'b0);
    cyc();
    chk_all("c3.move", 2'd3, 1'b0, 4'b1000, 1'b1, 1'b1);
    present_floor = 2'd3;
    cyc();
    chk_all("c3.door", 2'd3, 1'b1, 4'b0000, 1'b1, 1'b1);
    tick1(); chk("c3.t1", door_open, 1'b1);
    tick1(); chk("c3.t2", door_open, 1'b1);
    tick1(); chk("c3.t3", door_open, 1'b0);
    chk("c3.idle", busy, 1'b0);

    // Retarget to floor 2 while heading 0 -> 3.
    present_floor = 2'd0;
    cyc();
    chk("rt.park0", requested_floor, 2'd0);
    pulse_call(4'b1000);
    cyc();
    chk("rt.move3", requested_floor, 2'd3);
    present_floor = 2'd1;
    cyc();
    pulse_call(4'b0100);
    chk("rt.pend", pending, 8'h0C);
    cyc();
    chk("rt.req2", requested_floor, 2'd2);
    present_floor = 2'd2;
    cyc();
    chk_all("rt.door2", 2'd2, 1'b1, 4'b1000, 1'b1, 1'b1);
    repeat (3) tick1();
    chk("rt.close2", door_open, 1'b0);
    cyc();
    chk_all("rt.move3b", 2'd3, 1'b0, 4'b1000, 1'b1, 1'b1);
    present_floor = 2'd3;
    cyc();
    chk_all("rt.door3", 2'd3, 1'b1, 4'b0000, 1'b1, 1'b1);
    repeat (3) tick1();
    chk_all("rt.done", 2'd3, 1'b0, 4'b0000, 1'b1, 1'b0);

    // Direction flip: at floor 2 heading up, only floor 0 pending.
    present_floor = 2'd2;
    cyc();
    pulse_call(4'b0001);
    chk("flip.pend", pending, 8'h01);
    cyc();
    chk_all("flip.move", 2'd0, 1'b0, 4'b0001, 1'b0, 1'b1);
    // Arrival coincides with a fresh call for floor 0: the clear must win.
    present_floor = 2'd0;
    pulse_call(4'b0001);
    chk_all("flip.door", 2'd0, 1'b1, 4'b0000, 1'b0, 1'b1);
    repeat (3) tick1();
    chk("flip.close", door_open, 1'b0);

    // Dwell extension at floor 1, entered straight from IDLE.
    present_floor = 2'd1;
    pulse_call(4'b0010);
    chk("ext.pend", pending, 8'h02);
    cyc();
    chk_all("ext.door", 2'd1, 1'b1, 4'b0000, 1'b0, 1'b1);
    tick1(); tick1();
    chk("ext.t2", door_open, 1'b1);
    pulse_call(4'b0010);
    chk("ext.pend0", pending, 8'h00);
    chk("ext.open", door_open, 1'b1);
    tick1(); chk("ext.r1", door_open, 1'b1);
    tick1(); chk("ext.r2", door_open, 1'b1);
    tick1(); chk("ext.r3", door_open, 1'b0);
    chk("ext.idle", busy, 1'b0);

    // Asynchronous reset in the middle of a MOVING leg.
    present_floor = 2'd2;
    cyc();
    pulse_call(4'b1010);
    cyc();
    chk_all("ar.move", 2'd1, 1'b0, 4'b1010, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_all("ar.async", 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0);
    cyc();
    reset = 1'b0;
    repeat (3) cyc();
    chk_all("ar.after", 2'd2, 1'b0, 4'b0000, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
